// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-organised register memory.
// Inserts WAIT_STATES wait cycles per OKAY transfer; illegal transfers get a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [31:0]           mem_q [DEPTH];

  logic                  can_accept;
  logic                  accept;
  logic                  illegal;
  logic                  mem_we;
  logic [3:0]            byte_en;
  logic [31:0]           mem_word_d;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  unused_bits;

  // Address bits above the memory window and the BUSY/IDLE distinction are irrelevant here.
  assign unused_bits = ^{haddr[31:ADDR_WIDTH+2], htrans[0]};

  assign word_idx = addr_q[ADDR_WIDTH+1:2];

  always_comb begin
    can_accept = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
    accept     = can_accept && hsel && hready && htrans[1];
    illegal    = (hsize > 3'd2) ||
                 ((hsize == 3'd1) && haddr[0]) ||
                 ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    write_d    = write_q;
    size_d     = size_q;
    case (state_q)
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q - 4'd1;
        if (wait_cnt_q <= 4'd1) begin
          state_d = ST_DATA;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        // IDLE, DATA and ERR2 all leave the bus ready, so a new address phase may be taken here.
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = haddr[ADDR_WIDTH+1:0];
          write_d = hwrite;
          size_d  = hsize;
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  always_comb begin
    byte_en = 4'b1111;
    case (size_q)
      3'd0:    byte_en = 4'b0001 << addr_q[1:0];
      3'd1:    byte_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
    mem_word_d = mem_q[word_idx];
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) begin
        mem_word_d[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
    mem_we = (state_q == ST_DATA) && write_q;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      write_q    <= write_d;
      size_q     <= size_d;
    end
  end

  // Write commits on the edge that closes DATA, so a following read sees the new word.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[word_idx] <= mem_word_d;
    end
  end

  assign hreadyout = !((state_q == ST_WAIT) || (state_q == ST_ERR1));
  assign hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign hrdata    = ((state_q == ST_DATA) && !write_q) ? mem_q[word_idx] : '0;

endmodule
